// File: rtl/wb_host_seq_if.sv
// Command, response and Wishbone signal bundle for wb_host_seq.
// The slave modport is the sequencer's own view; master is the test logic that drives it.
interface wb_host_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic        busy;

   modport slave (
      input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
      output cmd_ready, rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o,
             wbm_sel_o, wbm_adr_o, wbm_dat_o, busy
   );

   modport master (
      output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
      input  cmd_ready, rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o,
             wbm_sel_o, wbm_adr_o, wbm_dat_o, busy
   );
endinterface

// File: rtl/wb_host_seq.sv
// Wishbone classic single-transfer initiator with ack timeout.
// Define WB_HOST_RETRY_EN to reissue timed-out cycles up to MAX_RETRIES times.
module wb_host_seq #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF,
   parameter int unsigned MAX_RETRIES    = 2
) (
   input logic         wb_clk_i,
   input logic         reset,
   wb_host_seq_if.slave bus
);

   localparam int unsigned        TimerW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

`ifdef WB_HOST_RETRY_EN
   localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   typedef enum logic [1:0] {StIdle, StBus, StResp, StBackoff} state_e;
   logic [RetryW-1:0] retry_q, retry_d;
`else
   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;
`endif

   state_e            state_q, state_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       dat_q, dat_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_dat_q, rsp_dat_d;
   logic              rsp_err_q, rsp_err_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              report_err;

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      timer_d     = timer_q;
      report_err  = 1'b0;
`ifdef WB_HOST_RETRY_EN
      retry_d     = retry_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               we_d    = bus.cmd_we;
               sel_d   = bus.cmd_sel;
               adr_d   = bus.cmd_adr;
               dat_d   = bus.cmd_dat;
               cyc_d   = 1'b1;
               timer_d = '0;
               state_d = StBus;
            end
         end
         StBus: begin
            // Ack in the final timer cycle takes priority over the timeout.
            if (bus.wbm_ack_i) begin
               cyc_d       = 1'b0;
               rsp_dat_d   = we_q ? 32'h0 : bus.wbm_dat_i;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = StResp;
            end else if (timer_q == TimerLast) begin
               cyc_d   = 1'b0;
               timer_d = '0;
`ifdef WB_HOST_RETRY_EN
               if (32'(retry_q) < MAX_RETRIES) begin
                  retry_d = retry_q + RetryW'(1);
                  state_d = StBackoff;
               end else begin
                  report_err = 1'b1;
               end
`else
               report_err = 1'b1;
`endif
            end else begin
               timer_d = timer_q + TimerW'(1);
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
`ifdef WB_HOST_RETRY_EN
               retry_d     = '0;
`endif
            end
         end
`ifdef WB_HOST_RETRY_EN
         StBackoff: begin
            cyc_d   = 1'b1;
            state_d = StBus;
         end
`endif
         default: state_d = StIdle;
      endcase

      if (report_err) begin
         rsp_dat_d   = ERR_DATA;
         rsp_err_d   = 1'b1;
         rsp_valid_d = 1'b1;
         state_d     = StResp;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         state_q     <= StIdle;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= 4'h0;
         adr_q       <= 32'h0;
         dat_q       <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= 32'h0;
         rsp_err_q   <= 1'b0;
         timer_q     <= '0;
`ifdef WB_HOST_RETRY_EN
         retry_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         timer_q     <= timer_d;
`ifdef WB_HOST_RETRY_EN
         retry_q     <= retry_d;
`endif
      end
   end

   assign bus.cmd_ready = (state_q == StIdle);
   assign bus.busy      = (state_q != StIdle);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_dat   = rsp_dat_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.wbm_cyc_o = cyc_q;
   assign bus.wbm_stb_o = cyc_q;
   assign bus.wbm_we_o  = we_q;
   assign bus.wbm_sel_o = sel_q;
   assign bus.wbm_adr_o = adr_q;
   assign bus.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_host_seq.sv
// Scoreboard bench for wb_host_seq: random commands against a memory-backed target with
// programmable ack delay; expectations come from a transaction-level model.
module tb_wb_host_seq;

   localparam int unsigned TO   = 16;
   localparam logic [31:0] ERRD = 32'hDEADBEEF;
   localparam int unsigned MR   = 2;
`ifdef WB_HOST_RETRY_EN
   localparam int BurstsTo = MR + 1;
`else
   localparam int BurstsTo = 1;
`endif

   logic wb_clk_i = 1'b0;
   logic reset    = 1'b1;
   always #5 wb_clk_i = ~wb_clk_i;

   wb_host_seq_if bus ();

   wb_host_seq #(
      .TIMEOUT_CYCLES(TO),
      .ERR_DATA      (ERRD),
      .MAX_RETRIES   (MR)
   ) dut (
      .wb_clk_i(wb_clk_i),
      .reset   (reset),
      .bus     (bus)
   );

   typedef struct {
      logic [31:0] dat;
      logic        err;
      int          stb;
      int          bursts;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc_no   = 0;
   int   hs_cyc   = 0;

   logic [31:0] model_mem [logic [31:0]];
   logic [31:0] tgt_mem   [logic [31:0]];

   int          tgt_delay = 1;
   int          tcnt      = 0;
   bit          stray_ack = 0;
   bit          bp_hold   = 0;
   logic        cur_we;
   logic [3:0]  cur_sel;
   logic [31:0] cur_adr, cur_dat;

   always @(posedge wb_clk_i) cyc_no <= cyc_no + 1;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc_no);
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return model_mem.exists(a) ? model_mem[a] : init_word(a);
   endfunction

   // Bus target: acks on the tgt_delay-th stb cycle (0 = never); junk data outside ack.
   always @(negedge wb_clk_i) begin
      logic [31:0] word;
      if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
         tcnt++;
         check("wb_hold", {bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o,
                           bus.wbm_we_o ? bus.wbm_dat_o : 32'h0},
               {cur_we, cur_sel, cur_adr, cur_we ? cur_dat : 32'h0});
         bus.wbm_ack_i = (tgt_delay != 0) && (tcnt == tgt_delay);
         word = tgt_mem.exists(bus.wbm_adr_o) ? tgt_mem[bus.wbm_adr_o]
                                              : init_word(bus.wbm_adr_o);
         if (bus.wbm_ack_i && bus.wbm_we_o)
            tgt_mem[bus.wbm_adr_o] = merge(word, bus.wbm_dat_o, bus.wbm_sel_o);
         bus.wbm_dat_i = (bus.wbm_ack_i && !bus.wbm_we_o) ? word : $urandom;
      end else begin
         tcnt          = 0;
         bus.wbm_ack_i = stray_ack;
         bus.wbm_dat_i = $urandom;
      end
   end

   always @(posedge wb_clk_i) begin
      #2;
      bus.rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   // Monitor: compares every presented response against the scoreboard head.
   int mon_stb = 0, mon_bursts = 0;
   bit prev_stb = 0, rsp_seen = 0;
   always @(negedge wb_clk_i) begin
      exp_t e;
      check("stb_eq_cyc", bus.wbm_stb_o, bus.wbm_cyc_o);
      if (!bus.busy) begin
         mon_stb    = 0;
         mon_bursts = 0;
      end
      if (bus.wbm_stb_o) begin
         mon_stb++;
         if (!prev_stb) mon_bursts++;
      end
      prev_stb = bus.wbm_stb_o;
      if (bus.rsp_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_rsp", bus.rsp_valid, 0);
         end else begin
            e = sb[0];
            if (!rsp_seen) begin
               rsp_seen = 1;
               check("rsp_latency", cyc_no - hs_cyc, e.stb + e.bursts);
               check("stb_cycles", mon_stb, e.stb);
               check("stb_bursts", mon_bursts, e.bursts);
            end
            check("rsp_dat", bus.rsp_dat, e.dat);
            check("rsp_err", bus.rsp_err, e.err);
            check("rsp_cyc_low", {bus.wbm_cyc_o, bus.cmd_ready}, 0);
            if (bus.rsp_ready) begin
               void'(sb.pop_front());
               rsp_seen = 0;
            end
         end
      end
   end

   task automatic prep(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int d, input bit expect_rsp);
      exp_t e;
      if (d >= 1 && d <= int'(TO)) begin
         e.dat    = we ? 32'h0 : model_rd(adr);
         e.err    = 1'b0;
         e.stb    = d;
         e.bursts = 1;
         if (we) model_mem[adr] = merge(model_rd(adr), dat, sel);
      end else begin
         e.dat    = ERRD;
         e.err    = 1'b1;
         e.stb    = int'(TO) * BurstsTo;
         e.bursts = BurstsTo;
      end
      if (expect_rsp) sb.push_back(e);
      cur_we      = we;
      cur_sel     = sel;
      cur_adr     = adr;
      cur_dat     = dat;
      tgt_delay   = d;
      bus.cmd_we  = we;
      bus.cmd_adr = adr;
      bus.cmd_dat = dat;
      bus.cmd_sel = sel;
   endtask

   task automatic handshake();
      int w = 0;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && w < 300) begin
         @(negedge wb_clk_i);
         w++;
      end
      if (w >= 300) check("cmd_ready_wait", bus.cmd_ready, 1);
      hs_cyc = cyc_no;
      @(negedge wb_clk_i);
      bus.cmd_valid = 1'b0;
      // Scramble the command port to show the bus side holds the latched copy.
      bus.cmd_we  = $urandom;
      bus.cmd_adr = $urandom;
      bus.cmd_dat = $urandom;
      bus.cmd_sel = $urandom;
   endtask

   task automatic wait_done();
      int w = 0;
      while (sb.size() != 0 && w < 300) begin
         @(negedge wb_clk_i);
         w++;
      end
      check("rsp_drained", sb.size(), 0);
      @(negedge wb_clk_i);
   endtask

   task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int d);
      prep(we, adr, dat, sel, d, 1'b1);
      handshake();
      wait_done();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      bus.cmd_valid = 1'b0;
      bus.cmd_we    = 1'b0;
      bus.cmd_adr   = 32'h0;
      bus.cmd_dat   = 32'h0;
      bus.cmd_sel   = 4'h0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      check("reset_wb", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}, 0);
      check("reset_adr_dat", {bus.wbm_adr_o, bus.wbm_dat_o}, 0);
      check("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_dat}, 0);
      check("reset_ready_busy", {bus.cmd_ready, bus.busy}, 2'b10);
      reset = 1'b0;
      @(negedge wb_clk_i);

      tgt_mem[32'h30000004]   = 32'h4669626F;
      model_mem[32'h30000004] = 32'h4669626F;

      send(1'b0, 32'h30000004, 32'h0, 4'hF, 1);
      send(1'b1, 32'h30000018, 32'h12345678, 4'hF, 2);
      send(1'b0, 32'h30000018, 32'h0, 4'hF, 3);
      send(1'b0, 32'h3000001C, 32'h0, 4'hF, 1);
      send(1'b0, 32'h30000008, 32'h0, 4'hF, 0);
      send(1'b0, 32'h3000000C, 32'h0, 4'hF, int'(TO));

      // Stray ack while idle must not produce a response.
      stray_ack = 1;
      repeat (4) begin
         @(negedge wb_clk_i);
         check("stray_ack_idle", {bus.rsp_valid, bus.busy, bus.wbm_cyc_o}, 0);
      end
      stray_ack = 0;
      @(negedge wb_clk_i);

      // Response backpressure with a second command waiting.
      bp_hold = 1;
      prep(1'b0, 32'h30000004, 32'h0, 4'hF, 2, 1'b1);
      handshake();
      w = 0;
      while (!bus.rsp_valid && w < 50) begin
         @(negedge wb_clk_i);
         w++;
      end
      prep(1'b1, 32'h30000020, 32'hA5A55A5A, 4'h5, 1, 1'b1);
      bus.cmd_valid = 1'b1;
      repeat (5) begin
         check("bp_hold", {bus.rsp_valid, bus.cmd_ready}, 2'b10);
         @(negedge wb_clk_i);
      end
      bp_hold = 0;
      handshake();
      wait_done();

      // Reset during the third stb cycle of a never-acked read.
      prep(1'b0, 32'h30000010, 32'h0, 4'hF, 0, 1'b0);
      handshake();
      repeat (2) @(negedge wb_clk_i);
      reset = 1'b1;
      @(negedge wb_clk_i);
      check("midreset_drop", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid}, 0);
      reset = 1'b0;
      @(negedge wb_clk_i);
      check("midreset_idle", {bus.cmd_ready, bus.busy}, 2'b10);
      repeat (3) begin
         @(negedge wb_clk_i);
         check("midreset_no_rsp", {bus.rsp_valid, bus.wbm_cyc_o}, 0);
      end

      for (int i = 0; i < 40; i++) begin
         logic        we;
         logic [31:0] adr;
         logic [3:0]  sel;
         int          d;
         we  = $urandom_range(0, 1);
         adr = 32'h30000000 + 32'($urandom_range(0, 15) * 4);
         sel = 4'($urandom_range(1, 15));
         d   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
         send(we, adr, $urandom, sel, d);
         repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
